local_eject_fifo: RTL



---
 rtl/local_eject_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/local_eject_fifo.sv
// Elastic flit buffer on the router local eject path with passive
// head/body/tail framing checker, packet counter and sticky first-error capture.
module local_eject_fifo #(
  parameter int FLIT_WIDTH = 34,
  parameter int DEPTH      = 4,
  parameter int SZ_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [FLIT_WIDTH-1:0]        flit_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [FLIT_WIDTH-1:0]        flit_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         pkt_done_o,
  output logic [CNT_WIDTH-1:0]         pkt_cnt_o,
  output logic                         err_o,
  output logic [2:0]                   err_code_o,
  input  logic                         err_clr_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {FT_HEAD, FT_BODY, FT_TAIL, FT_RSVD} ftype_t;
  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [FLIT_WIDTH-1:0] last_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         occ_q;
  logic                  push, pop;

  state_t                state_q, nxt_state;
  logic [SZ_WIDTH-1:0]   rem_q, nxt_rem;
  logic                  hit_done, hit_err;
  logic [2:0]            cause;
  ftype_t                ftype;
  logic [SZ_WIDTH-1:0]   fsize;

  assign ready_o     = (occ_q != OW'(DEPTH));
  assign valid_o     = (occ_q != '0);
  assign occupancy_o = occ_q;
  assign push        = valid_i & ready_o;
  assign pop         = valid_o & ready_i;
  // When empty the read slot is stale, so present the last popped flit instead.
  assign flit_o      = valid_o ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= flit_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign ftype = ftype_t'(flit_i[FLIT_WIDTH-1 -: 2]);
  assign fsize = flit_i[SZ_WIDTH-1:0];

  always_comb begin
    nxt_state = state_q;
    nxt_rem   = rem_q;
    hit_done  = 1'b0;
    hit_err   = 1'b0;
    cause     = '0;
    if (push) begin
      case (ftype)
        FT_HEAD: begin
          if (state_q == IN_PKT) begin
            hit_err = 1'b1;
            cause   = 3'd2;
          end
          if (fsize == '0) begin
            hit_done  = 1'b1;
            nxt_state = IDLE;
            nxt_rem   = '0;
          end else begin
            nxt_state = IN_PKT;
            nxt_rem   = fsize;
          end
        end
        FT_BODY: begin
          if (state_q == IDLE) begin
            hit_err = 1'b1;
            cause   = 3'd1;
          end else if (rem_q > SZ_WIDTH'(1)) begin
            nxt_rem = rem_q - SZ_WIDTH'(1);
          end else begin
            hit_err   = 1'b1;
            cause     = 3'd4;
            nxt_state = IDLE;
            nxt_rem   = '0;
          end
        end
        FT_TAIL: begin
          if (state_q == IDLE) begin
            hit_err = 1'b1;
            cause   = 3'd1;
          end else if (rem_q == SZ_WIDTH'(1)) begin
            hit_done = 1'b1;
          end else begin
            hit_err = 1'b1;
            cause   = 3'd3;
          end
          nxt_state = IDLE;
          nxt_rem   = '0;
        end
        default: begin
          hit_err   = 1'b1;
          cause     = 3'd5;
          nxt_state = IDLE;
          nxt_rem   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pkt_done_o <= 1'b0;
      pkt_cnt_o  <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      state_q    <= nxt_state;
      rem_q      <= nxt_rem;
      pkt_done_o <= hit_done;
      if (hit_done) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
      // A clear coinciding with a new error re-arms capture for that error.
      if (hit_err) begin
        err_o <= 1'b1;
        if (!err_o || err_clr_i) err_code_o <= cause;
      end else if (err_clr_i) begin
        err_o      <= 1'b0;
        err_code_o <= '0;
      end
    end
  end

endmodule
